instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sequential instruction-fetch front end that produces the 6-bit opcode stream the control decoder consumes, and consumes the decoder's Branch/BranchType/Jump (active-low)/jr outputs to choose the next PC.
- Sits between instruction memory (variable-latency req/ack) and the single-cycle datapath.
- Holds one fetched instruction until the datapath accepts it.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-low reset.
- imem_req_o  output  1  fetch request, held until imem_ack_i.
- imem_addr_o  output  ADDR_W  fetch address; stable while imem_req_o=1.
- imem_ack_i  input  1  read data valid this cycle.
- imem_rdata_i  input  32  instruction word.
- instr_valid_o  output  1  buffered instruction valid.
- instr_ready_i  input  1  datapath accepts instruction this cycle.
- instr_o  output  32  buffered instruction.
- instr_op_o  output  6  instr_o[31:26], to decoder.
- pc_o  output  ADDR_W  PC of buffered instruction.
- pc_plus4_o  output  ADDR_W  pc_o+4 (jal link value).
- branch_i  input  1  decoder Branch.
- branch_type_i  input  2  00 beq, 01 ble, 10 blt, 11 bnez.
- jump_n_i  input  1  decoder Jump, active-low (0 = j/jal).
- jr_i  input  1  jr detected by ALU control.
- zero_i  input  1  ALU zero.
- neg_i  input  1  ALU result sign.
- rs_data_i  input  32  rs value for jr.
- align_err_o  output  1  sticky: redirect target misaligned.

Behaviour:
- Reset (rst_i=0, asynchronous): PC=RESET_PC; state=FETCH_REQ; imem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=RESET_PC, align_err_o=0. No request in the reset cycle. The first request is issued on the first clock edge after rst_i rises.
- FSM states: FETCH_REQ, WAIT_ACK, HOLD, HALT.
- FETCH_REQ: drive imem_req_o=1 with imem_addr_o=PC; go to WAIT_ACK.
- WAIT_ACK: keep imem_req_o=1. On imem_ack_i: latch imem_rdata_i into instr_o, pc_o=PC, instr_valid_o=1 next cycle, imem_req_o=0, go to HOLD. Minimum latency from request to valid is 2 cycles.
- HOLD: instr_valid_o=1, outputs stable. Accept = instr_valid_o & instr_ready_i. Next PC is evaluated combinationally in the accept cycle, with this priority:
  1. jr_i=1 → rs_data_i.
  2. jump_n_i=0 → {pc_plus4[31:28], instr_o[25:0], 2'b00}.
  3. branch_i=1 and taken → pc_plus4 + (sign-extended instr_o[15:0] << 2).
  4. otherwise → pc_plus4.
- Branch taken conditions: beq: zero_i; ble: zero_i|neg_i; blt: neg_i & ~zero_i; bnez: ~zero_i.
- On accept: PC<=next PC, instr_valid_o<=0, go to FETCH_REQ. Back-to-back throughput is one instruction per 3 cycles with a 1-cycle-latency memory.
- No accept: hold all outputs; branch/jump inputs are ignored.
- Misaligned target: if next PC[1:0]!=0 at accept, set align_err_o=1 (sticky until reset), go to HALT. HALT issues no requests, instr_valid_o=0.
- Address arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0 silently.
- imem_ack_i outside WAIT_ACK is ignored.
- Reset asserted mid-request: imem_req_o drops asynchronously; any later ack is discarded.

Optional Feature:
- IFU_PERF_CNT_EN defined: adds two outputs, fetch_cnt_o[31:0] and redirect_cnt_o[31:0], both reset to 0.
  - fetch_cnt_o increments on each accept.
  - redirect_cnt_o increments on each accept whose next PC != pc_plus4.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0, memory ack 1 cycle later with 32'h2008_0005, ready=1 → imem_addr_o=0, instr_op_o=6'b001000, next imem_addr_o=4.
- HOLD with ready=0 for 5 cycles, then ready=1 → instr_o, pc_o, imem_req_o stable for all 5 cycles; exactly one fetch to pc+4 afterwards.
- beq at pc=8, imm=16'hFFFE, zero_i=1 → next addr 4. Same with zero_i=0 → next addr 12.
- ble/blt/bnez at pc=0, imm=3:
  - ble, neg=1, zero=0 → 16.
  - blt, zero=1 → 4.
  - bnez, zero=0 → 16.
- j at pc=32'h1000_0000, target field 26'h40 → next addr 32'h1000_0100. jr with rs_data_i=32'h0000_0022 → align_err_o=1, HALT, no further imem_req_o.
- Assert rst_i=0 while in WAIT_ACK, then pulse imem_ack_i → imem_req_o=0 immediately, ack ignored, fetch restarts at RESET_PC. With IFU_PERF_CNT_EN: 3 accepts including 1 taken branch → fetch_cnt_o=3, redirect_cnt_o=1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Sequential instruction-fetch front end. It requests one word at a time from
// a variable-latency instruction memory and buffers it until the datapath
// accepts it. It then picks the next PC from the decoder's jr / jump / branch
// controls and the ALU flags.
//
// Optional feature: define IFU_PERF_CNT_EN to add the fetch_cnt_o and
// redirect_cnt_o performance counters. They are absent by default.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   imem_req_o/addr_o       fetch request and address, held until imem_ack_i
//   imem_ack_i/rdata_i      read data valid strobe and instruction word
//   instr_valid_o/ready_i   buffered-instruction handshake with the datapath
//   instr_o, instr_op_o     buffered instruction and its opcode field
//   pc_o, pc_plus4_o        PC of the buffered instruction and PC+4 (jal link)
//   branch_i, branch_type_i decoder branch controls (00 beq 01 ble 10 blt 11 bnez)
//   jump_n_i, jr_i          active-low j/jal, jr
//   zero_i, neg_i           ALU zero / sign flags
//   rs_data_i               jr target
//   align_err_o             sticky misaligned-redirect flag; the unit halts
//   fetch_cnt_o             (IFU_PERF_CNT_EN) accepted instructions
//   redirect_cnt_o          (IFU_PERF_CNT_EN) accepts whose next PC != PC+4
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [5:0]        instr_op_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    input  logic              branch_i,
    input  logic [1:0]        branch_type_i,
    input  logic              jump_n_i,
    input  logic              jr_i,
    input  logic              zero_i,
    input  logic              neg_i,
    input  logic [31:0]       rs_data_i,
    output logic              align_err_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       redirect_cnt_o
`endif
);

    typedef enum logic [1:0] {FETCH_REQ, WAIT_ACK, HOLD, HALT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;          // fetch PC
    logic [ADDR_W-1:0] ipc_q, ipc_d;        // PC of the buffered instruction
    logic [31:0]       instr_q, instr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] next_pc;
    logic              taken;
    logic              accept;

    // Redirect selection. It is evaluated every cycle but used only on accept.
    // NOTE: every signal driven here gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        pc_plus4      = ipc_q + ADDR_W'(4);
        jump_target   = {pc_plus4[ADDR_W-1:28], instr_q[25:0], 2'b00};
        branch_target = pc_plus4 + {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
        taken         = 1'b0;
        unique case (branch_type_i)
            2'b00: taken = zero_i;
            2'b01: taken = zero_i | neg_i;
            2'b10: taken = neg_i & ~zero_i;
            2'b11: taken = ~zero_i;
        endcase
        next_pc = pc_plus4;
        if (jr_i)                 next_pc = rs_data_i[ADDR_W-1:0];
        else if (!jump_n_i)       next_pc = jump_target;
        else if (branch_i && taken) next_pc = branch_target;
    end

    // valid_q is set only in HOLD, so an accept can happen only there.
    assign accept = valid_q & instr_ready_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            FETCH_REQ: begin
                // The request is registered, so the reset cycle never requests.
                req_d   = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        state_d = FETCH_REQ;
                    end
                end
            end
            HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
            ipc_q   <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else if (accept) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (next_pc != pc_plus4) redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o    = fetch_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`endif

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_op_o    = instr_q[31:26];
    assign pc_o          = ipc_q;
    assign pc_plus4_o    = pc_plus4;
    assign align_err_o   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A directed vector table covers the
// listed corner cases. Randomized fetch/accept traffic is then checked against
// a next-PC reference model written from the redirect rules. Hand-written
// sequences cover the reset-cycle behavior and reset during a request.
// Define IFU_PERF_CNT_EN for both files to also check the counters.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [5:0]  instr_op_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        branch_i = 1'b0;
    logic [1:0]  branch_type_i = 2'b00;
    logic        jump_n_i = 1'b1;
    logic        jr_i = 1'b0;
    logic        zero_i = 1'b0;
    logic        neg_i = 1'b0;
    logic [31:0] rs_data_i = '0;
    logic        align_err_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] redirect_cnt_o;
`endif

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_op_o    (instr_op_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .branch_i      (branch_i),
        .branch_type_i (branch_type_i),
        .jump_n_i      (jump_n_i),
        .jr_i          (jr_i),
        .zero_i        (zero_i),
        .neg_i         (neg_i),
        .rs_data_i     (rs_data_i),
        .align_err_o   (align_err_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .redirect_cnt_o(redirect_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    int          exp_accepts;
    int          exp_redirects;

    typedef struct {
        logic [31:0] word;
        logic        br;
        logic [1:0]  bt;
        logic        jn;
        logic        jr;
        logic        z;
        logic        n;
        logic [31:0] rs;
        int          lat;
        int          stall;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next PC from the redirect rules, using plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic br, input logic [1:0] bt,
                                             input logic jn, input logic jr,
                                             input logic z, input logic n,
                                             input logic [31:0] rs);
        logic [31:0] p4 = pc + 32'd4;
        logic        tk;
        int          off;
        if (jr) return rs;
        if (!jn) return (p4 & 32'hF000_0000) + word[25:0] * 4;
        case (bt)
            2'd0:    tk = z;
            2'd1:    tk = z | n;
            2'd2:    tk = n & !z;
            default: tk = !z;
        endcase
        off = $signed(word[15:0]);
        if (br && tk) return p4 + 32'(off * 4);
        return p4;
    endfunction

    function automatic vec_t mk(input logic [31:0] word, input logic br, input logic [1:0] bt,
                                input logic jn, input logic jr, input logic z, input logic n,
                                input logic [31:0] rs, input int lat, input int stall,
                                input logic [31:0] exp_next);
        vec_t v;
        v.word = word; v.br = br; v.bt = bt; v.jn = jn; v.jr = jr; v.z = z; v.n = n;
        v.rs = rs; v.lat = lat; v.stall = stall; v.exp_next = exp_next;
        return v;
    endfunction

    task automatic check_perf();
`ifdef IFU_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt_o, 32'(exp_accepts));
        check("redirect_cnt", redirect_cnt_o, 32'(exp_redirects));
`endif
    endtask

    task automatic set_idle();
        instr_ready_i = 1'b0;
        imem_ack_i    = 1'b0;
        branch_i      = 1'b0;
        branch_type_i = 2'b00;
        jump_n_i      = 1'b1;
        jr_i          = 1'b0;
        zero_i        = 1'b0;
        neg_i         = 1'b0;
    endtask

    // Reset, check the reset state, release, and check the first request edge.
    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        set_idle();
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_req", imem_req_o, 32'd0);
        check("rst_valid", instr_valid_o, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'h0000_0000);
        check("rst_addr", imem_addr_o, 32'h0000_0000);
        check("rst_err", align_err_o, 32'd0);
        exp_pc        = 32'h0000_0000;
        exp_accepts   = 0;
        exp_redirects = 0;
        check_perf();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("first_req", imem_req_o, 32'd1);
        check("first_addr", imem_addr_o, 32'h0000_0000);
    endtask

    // Wait for a request to addr, hold it for lat cycles, then ack with word.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int lat);
        int n = 0;
        while (imem_req_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("req_seen", imem_req_o, 32'd1);
        check("fetch_addr", imem_addr_o, addr);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk_i);
            check("req_held", {imem_req_o, instr_valid_o}, 32'b10);
            check("addr_stable", imem_addr_o, addr);
        end
        imem_ack_i   = 1'b1;
        imem_rdata_i = word;
        @(negedge clk_i);
        imem_ack_i   = 1'b0;
        imem_rdata_i = $urandom;
        check("valid_set", instr_valid_o, 32'd1);
        check("req_drop", imem_req_o, 32'd0);
        check("instr", instr_o, word);
        check("opcode", instr_op_o, 32'(word[31:26]));
        check("pc", pc_o, addr);
        check("pc_plus4", pc_plus4_o, addr + 32'd4);
    endtask

    // Fetch one instruction at exp_pc, stall, accept with the given controls.
    task automatic run_one(input vec_t v);
        do_fetch(exp_pc, v.word, v.lat);
        for (int i = 0; i < v.stall; i++) begin
            // Controls and stray acks must be ignored while not accepting.
            branch_i      = 1'($urandom);
            branch_type_i = 2'($urandom);
            jump_n_i      = 1'($urandom);
            jr_i          = 1'($urandom);
            zero_i        = 1'($urandom);
            rs_data_i     = $urandom;
            imem_ack_i    = 1'($urandom);
            @(negedge clk_i);
            imem_ack_i = 1'b0;
            check("hold_valid", instr_valid_o, 32'd1);
            check("hold_req", imem_req_o, 32'd0);
            check("hold_instr", instr_o, v.word);
            check("hold_pc", pc_o, exp_pc);
        end
        branch_i      = v.br;
        branch_type_i = v.bt;
        jump_n_i      = v.jn;
        jr_i          = v.jr;
        zero_i        = v.z;
        neg_i         = v.n;
        rs_data_i     = v.rs;
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        set_idle();
        exp_accepts++;
        if (v.exp_next != exp_pc + 32'd4) exp_redirects++;
        check("valid_clear", instr_valid_o, 32'd0);
        if (v.exp_next[1:0] != 2'b00) begin
            check("align_err_set", align_err_o, 32'd1);
            for (int i = 0; i < 6; i++) begin
                imem_ack_i = 1'($urandom);
                @(negedge clk_i);
                check("halt_quiet", {imem_req_o, instr_valid_o, align_err_o}, 32'b001);
            end
            imem_ack_i = 1'b0;
        end else begin
            check("align_err_clear", align_err_o, 32'd0);
        end
        exp_pc = v.exp_next;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //                word          br bt    jn    jr    z     n     rs            lat st  next
        vecs[0]  = mk(32'h2008_0005, 0, 2'd0, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_0004);
        vecs[1]  = mk(32'h0000_0000, 0, 2'd0, 1, 0, 0, 0, 32'h0,         2, 5, 32'h0000_0008);
        vecs[2]  = mk(32'h1000_FFFE, 1, 2'd0, 1, 0, 1, 0, 32'h0,         1, 0, 32'h0000_0004);
        vecs[3]  = mk(32'h0000_0000, 0, 2'd0, 1, 0, 0, 0, 32'h0,         3, 1, 32'h0000_0008);
        vecs[4]  = mk(32'h1000_FFFE, 1, 2'd0, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_000C);
        vecs[5]  = mk(32'h0800_0000, 0, 2'd0, 0, 0, 0, 0, 32'h0,         1, 0, 32'h0000_0000);
        vecs[6]  = mk(32'h1000_0003, 1, 2'd1, 1, 0, 0, 1, 32'h0,         1, 0, 32'h0000_0010);
        vecs[7]  = mk(32'h0800_0000, 0, 2'd0, 0, 0, 0, 0, 32'h0,         1, 0, 32'h0000_0000);
        vecs[8]  = mk(32'h1000_0003, 1, 2'd2, 1, 0, 1, 1, 32'h0,         2, 0, 32'h0000_0004);
        vecs[9]  = mk(32'h0800_0000, 0, 2'd0, 0, 0, 0, 0, 32'h0,         1, 0, 32'h0000_0000);
        vecs[10] = mk(32'h1000_0003, 1, 2'd3, 1, 0, 0, 0, 32'h0,         1, 2, 32'h0000_0010);
        vecs[11] = mk(32'h0000_0000, 0, 2'd0, 1, 1, 0, 0, 32'h1000_0000, 1, 0, 32'h1000_0000);
        vecs[12] = mk(32'h0800_0040, 0, 2'd0, 0, 0, 0, 0, 32'h0,         1, 0, 32'h1000_0100);
        vecs[13] = mk(32'h0000_0000, 1, 2'd0, 0, 1, 1, 0, 32'h0,         1, 0, 32'h0000_0000);
        vecs[14] = mk(32'h0800_0010, 1, 2'd0, 0, 0, 1, 0, 32'h0,         1, 0, 32'h0000_0040);
        vecs[15] = mk(32'h0000_0000, 0, 2'd0, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_0044);
        vecs[16] = mk(32'h0000_0000, 0, 2'd0, 1, 1, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC);
        vecs[17] = mk(32'h0000_0000, 0, 2'd0, 1, 0, 0, 0, 32'h0,         2, 0, 32'h0000_0000);
        vecs[18] = mk(32'h0000_0000, 1, 2'd3, 1, 0, 1, 0, 32'h0,         1, 0, 32'h0000_0004);
        vecs[19] = mk(32'h0000_0000, 0, 2'd0, 1, 1, 0, 0, 32'h0000_0022, 1, 0, 32'h0000_0022);

        // Directed table, ending in a misaligned jr that halts the unit.
        do_reset();
        for (int i = 0; i < 20; i++) run_one(vecs[i]);
        check_perf();

        // Randomized traffic checked against the reference model.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            v.word  = $urandom;
            v.br    = 1'($urandom);
            v.bt    = 2'($urandom);
            v.jr    = ($urandom_range(0, 7) == 0);
            v.jn    = ($urandom_range(0, 5) != 0);
            v.z     = 1'($urandom);
            v.n     = 1'($urandom);
            v.rs    = $urandom & 32'hFFFF_FFFC;
            v.lat   = $urandom_range(1, 3);
            v.stall = $urandom_range(0, 2);
            v.exp_next = ref_next(exp_pc, v.word, v.br, v.bt, v.jn, v.jr, v.z, v.n, v.rs);
            run_one(v);
        end
        check_perf();

        // Reset during WAIT_ACK: request drops at once and acks are discarded.
        do_reset();
        @(negedge clk_i);
        check("mid_req_active", imem_req_o, 32'd1);
        rst_i = 1'b0;
        #1;
        check("mid_req_async_drop", imem_req_o, 32'd0);
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        check("mid_valid_in_rst", instr_valid_o, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        check("mid_ack_ignored", instr_valid_o, 32'd0);
        check("mid_restart_req", imem_req_o, 32'd1);
        check("mid_restart_addr", imem_addr_o, 32'h0000_0000);
        exp_pc = 32'h0000_0000;
        run_one(mk(32'h2008_0005, 0, 2'd0, 1, 0, 0, 0, 32'h0, 1, 0, 32'h0000_0004));
        run_one(mk(32'h1000_0003, 1, 2'd0, 1, 0, 1, 0, 32'h0, 1, 0, 32'h0000_0014));
        run_one(mk(32'h0000_0000, 0, 2'd0, 1, 0, 0, 0, 32'h0, 1, 0, 32'h0000_0018));
        check_perf();
        do_fetch(exp_pc, 32'h0000_0000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
